// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard
//   RISC-V integer register file with a per-register pending scoreboard.
//   x0 is hardwired to zero. A write to a register is bypassed to a read of the
//   same register in the same cycle. On reset a sequential sweep zeroes
//   x1..x(DEPTH-1), so the storage array itself needs no reset.
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   Add_A/Add_B       read addresses
//   Info_A/Info_B     read data (combinational)
//   Add_Dest, Write_Data, Write_En
//                     writeback port
//   Issue_En, Issue_Dest
//                     marks a destination as having an in-flight producer
//   Pend_A/Pend_B     operand has an outstanding producer (combinational)
//   Busy              clear sweep in progress; writes and issues are dropped
module reg_file_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] Add_A,
  input  logic [ADDR_W-1:0] Add_B,
  output logic [DATA_W-1:0] Info_A,
  output logic [DATA_W-1:0] Info_B,
  input  logic [ADDR_W-1:0] Add_Dest,
  input  logic [DATA_W-1:0] Write_Data,
  input  logic              Write_En,
  input  logic              Issue_En,
  input  logic [ADDR_W-1:0] Issue_Dest,
  output logic              Pend_A,
  output logic              Pend_B,
  output logic              Busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [DEPTH-1:0]    pend_q;
  logic [DATA_W-1:0]   mem_q [1:DEPTH-1];

  logic idle;
  logic wr_ok;
  logic iss_ok;

  assign idle   = (state_q == IDLE);
  assign wr_ok  = idle && !RST && Write_En && (Add_Dest != '0);
  assign iss_ok = idle && !RST && Issue_En && (Issue_Dest != '0);

  // Control state and scoreboard.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= CLEAR;
      cnt_q   <= ADDR_W'(1);
      pend_q  <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          cnt_q <= cnt_q + ADDR_W'(1);
          if (cnt_q == ADDR_W'(DEPTH - 1))
            state_q <= IDLE;
        end
        IDLE: begin
          // Clear before set: a same-cycle issue to the written register is a
          // younger producer, so its pending bit must survive.
          if (wr_ok)
            pend_q[Add_Dest] <= 1'b0;
          if (iss_ok)
            pend_q[Issue_Dest] <= 1'b1;
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  // Storage array: no reset, cleared by the sweep instead.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state_q == CLEAR)
        mem_q[cnt_q] <= '0;
      else if (wr_ok)
        mem_q[Add_Dest] <= Write_Data;
    end
  end

  always_comb begin
    Info_A = '0;
    Pend_A = 1'b0;
    if (idle && (Add_A != '0)) begin
      if (Write_En && (Add_Dest == Add_A)) begin
        Info_A = Write_Data;
      end else begin
        Info_A = mem_q[Add_A];
        Pend_A = pend_q[Add_A];
      end
    end
  end

  always_comb begin
    Info_B = '0;
    Pend_B = 1'b0;
    if (idle && (Add_B != '0)) begin
      if (Write_En && (Add_Dest == Add_B)) begin
        Info_B = Write_Data;
      end else begin
        Info_B = mem_q[Add_B];
        Pend_B = pend_q[Add_B];
      end
    end
  end

  assign Busy = (state_q == CLEAR);

endmodule

// File: tb/tb_reg_file_scoreboard.sv
module tb_reg_file_scoreboard;

  logic        CLK;
  logic        rst;
  logic [4:0]  aa, ab, ad, idst;
  logic [31:0] wd;
  logic        we, ie;
  logic [31:0] info_a, info_b;
  logic        pend_a, pend_b, busy;

  logic        s_rst;
  logic [2:0]  s_aa, s_ab, s_ad, s_idst;
  logic [15:0] s_wd;
  logic        s_we, s_ie;
  logic [15:0] s_info_a, s_info_b;
  logic        s_pend_a, s_pend_b, s_busy;

  int checks = 0;
  int errors = 0;
  int n;

  reg_file_scoreboard #(.DATA_W(32), .ADDR_W(5)) dut (
    .CLK(CLK), .RST(rst), .Add_A(aa), .Add_B(ab), .Info_A(info_a), .Info_B(info_b),
    .Add_Dest(ad), .Write_Data(wd), .Write_En(we), .Issue_En(ie), .Issue_Dest(idst),
    .Pend_A(pend_a), .Pend_B(pend_b), .Busy(busy)
  );

  reg_file_scoreboard #(.DATA_W(16), .ADDR_W(3)) dut_s (
    .CLK(CLK), .RST(s_rst), .Add_A(s_aa), .Add_B(s_ab), .Info_A(s_info_a), .Info_B(s_info_b),
    .Add_Dest(s_ad), .Write_Data(s_wd), .Write_En(s_we), .Issue_En(s_ie), .Issue_Dest(s_idst),
    .Pend_A(s_pend_a), .Pend_B(s_pend_b), .Busy(s_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; aa = '0; ab = '0; ad = '0; idst = '0; wd = '0; we = 1'b0; ie = 1'b0;
    s_rst = 1'b1; s_aa = '0; s_ab = '0; s_ad = '0; s_idst = '0; s_wd = '0; s_we = 1'b0; s_ie = 1'b0;

    // Reset held for 3 cycles
    repeat (3) @(negedge CLK);
    aa = 5'd5; ab = 5'd31; #1;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_info_a", info_a, 32'h0);
    chk("rst_info_b", info_b, 32'h0);
    chk("rst_pend_a", 32'(pend_a), 32'd0);

    rst = 1'b0;
    n = 0;
    do begin @(negedge CLK); n++; end while (busy && n < 100);
    chk("sweep_len", 32'(n), 32'd31);

    for (int i = 0; i < 32; i++) begin
      aa = 5'(i); ab = 5'(31 - i); #1;
      chk("clr_info_a", info_a, 32'h0);
      chk("clr_info_b", info_b, 32'h0);
      chk("clr_pend_a", 32'(pend_a), 32'd0);
      chk("clr_pend_b", 32'(pend_b), 32'd0);
    end

    // Write x5, then attempted write to x0
    @(negedge CLK);
    we = 1'b1; ad = 5'd5; wd = 32'hDEADBEEF;
    @(negedge CLK);
    ad = 5'd0; wd = 32'h12345678; ab = 5'd0; #1;
    chk("x0_bypass_b", info_b, 32'h0);
    @(negedge CLK);
    we = 1'b0; aa = 5'd5; ab = 5'd0; #1;
    chk("x5_read", info_a, 32'hDEADBEEF);
    chk("x0_read", info_b, 32'h0);

    // Bypass on x7
    we = 1'b1; ad = 5'd7; wd = 32'h1;
    @(negedge CLK);
    we = 1'b0; aa = 5'd7; #1;
    chk("x7_init", info_a, 32'h1);
    we = 1'b1; ad = 5'd7; wd = 32'hCAFEF00D; ab = 5'd7; #1;
    chk("bypass_a", info_a, 32'hCAFEF00D);
    chk("bypass_b", info_b, 32'hCAFEF00D);
    chk("bypass_pend", 32'(pend_a), 32'd0);
    @(negedge CLK);
    we = 1'b0; #1;
    chk("x7_array", info_a, 32'hCAFEF00D);

    // Scoreboard on x9
    ie = 1'b1; idst = 5'd9; aa = 5'd9; ab = 5'd10; #1;
    chk("pend_pre_issue", 32'(pend_a), 32'd0);
    @(negedge CLK);                       // edge k passed
    ie = 1'b0; #1;
    chk("pend_k1", 32'(pend_a), 32'd1);
    chk("pend_other", 32'(pend_b), 32'd0);
    @(negedge CLK); #1;
    chk("pend_k2", 32'(pend_a), 32'd1);
    @(negedge CLK);
    we = 1'b1; ad = 5'd9; wd = 32'h00000099; #1;
    chk("pend_wb_comb", 32'(pend_a), 32'd0);
    chk("info_wb_comb", info_a, 32'h00000099);
    @(negedge CLK);
    we = 1'b0; #1;
    chk("pend_cleared", 32'(pend_a), 32'd0);
    ie = 1'b1; idst = 5'd9; we = 1'b1; ad = 5'd9; wd = 32'h000000AA; #1;
    chk("pend_same_comb", 32'(pend_a), 32'd0);
    @(negedge CLK);
    ie = 1'b0; we = 1'b0; #1;
    chk("pend_same_next", 32'(pend_a), 32'd1);
    chk("info_same_next", info_a, 32'h000000AA);

    // Issue to x0 never sets pending
    ie = 1'b1; idst = 5'd0;
    @(negedge CLK);
    ie = 1'b0; aa = 5'd0; #1;
    chk("pend_x0", 32'(pend_a), 32'd0);

    // Reset mid-sweep, with ignored ops on x4
    rst = 1'b1;
    @(negedge CLK);
    rst = 1'b0; aa = 5'd7; ab = 5'd9; #1;
    chk("sweep_info_a", info_a, 32'h0);
    chk("sweep_pend_b", 32'(pend_b), 32'd0);
    for (int c = 1; c < 10; c++) begin
      if (c == 5) begin
        ie = 1'b1; idst = 5'd4; we = 1'b1; ad = 5'd4; wd = 32'h44444444;
      end else begin
        ie = 1'b0; we = 1'b0;
      end
      @(negedge CLK);
    end
    ie = 1'b0; we = 1'b0;
    rst = 1'b1;
    @(negedge CLK);
    rst = 1'b0;
    n = 0;
    do begin
      // x4 is already swept by cycle 20, so an accepted write would persist
      if (n == 20) begin
        ie = 1'b1; idst = 5'd4; we = 1'b1; ad = 5'd4; wd = 32'h55555555;
      end else begin
        ie = 1'b0; we = 1'b0;
      end
      @(negedge CLK); n++;
    end while (busy && n < 100);
    ie = 1'b0; we = 1'b0;
    chk("resweep_len", 32'(n), 32'd31);
    aa = 5'd4; ab = 5'd9; #1;
    chk("x4_data", info_a, 32'h0);
    chk("x4_pend", 32'(pend_a), 32'd0);
    chk("x9_pend_rst", 32'(pend_b), 32'd0);
    chk("x9_data_rst", info_b, 32'h0);
    aa = 5'd7; ab = 5'd5; #1;
    chk("x7_rst", info_a, 32'h0);
    chk("x5_rst", info_b, 32'h0);

    // Small instance: ADDR_W=3, DATA_W=16
    s_rst = 1'b0;
    n = 0;
    do begin @(negedge CLK); n++; end while (s_busy && n < 100);
    chk("s_sweep_len", 32'(n), 32'd7);
    s_we = 1'b1; s_ad = 3'd7; s_wd = 16'hFFFF; s_ab = 3'd7; #1;
    chk("s_bypass", 32'(s_info_b), 32'h0000FFFF);
    @(negedge CLK);
    s_we = 1'b0; s_aa = 3'd7; s_ab = 3'd6; #1;
    chk("s_x7", 32'(s_info_a), 32'h0000FFFF);
    chk("s_x6", 32'(s_info_b), 32'h0);
    chk("s_pend", 32'(s_pend_a), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
